// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch sequencer.
// Each instruction goes FETCH (request to imem until accepted), then WAIT
// (for the response word), then EXEC (one cycle in which the decoder and
// datapath act on the latched word and the next PC is committed).
// A misaligned next PC parks the unit in TRAP until reset. halt parks it
// in HALTED after the current instruction retires.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata : fetch handshake
//   instr, opcode, funct3, funct7, instr_valid            : to decoder/datapath
//   branch, pc_update, pc_target_src, imm, alu_result     : next-PC controls
//   halt                                                  : stop after current instr
//   pc, pc_plus4                                          : to datapath
//   trap, trap_addr                                       : sticky misalignment report
//   retired                                               : committed instruction count
module pc_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic                  instr_valid,
  input  logic                  branch,
  input  logic                  pc_update,
  input  logic                  pc_target_src,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  halt,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  trap,
  output logic [DATA_WIDTH-1:0] trap_addr,
  output logic [31:0]           retired
);

  localparam int unsigned RET_W = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_EXEC   = 3'd2,
    S_HALTED = 3'd3,
    S_TRAP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] trap_addr_q, trap_addr_d;
  logic [RET_W-1:0]      retired_q, retired_d;
  logic                  trap_q, trap_d;
  logic                  req_q;
  logic                  valid_q;

  logic                  taken;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] next_pc;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Next-PC candidate; only committed in EXEC. JALR target has bit 0 cleared.
  always_comb begin
    taken   = branch | pc_update;
    target  = pc_target_src ? (alu_result & ~DATA_WIDTH'(1)) : (pc_q + imm);
    next_pc = taken ? target : pc_plus4;
  end

  // Next-state and next-value logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    case (state_q)
      S_FETCH: begin
        // rvalid deliberately ignored here: drops stale responses after reset
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (next_pc[1:0] != 2'b00) begin
          state_d     = S_TRAP;
          trap_d      = 1'b1;
          trap_addr_d = next_pc;
        end else begin
          pc_d      = next_pc;
          retired_d = retired_q + RET_W'(1);
          state_d   = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (!halt) state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath registers; req/valid are registered decodes of next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      retired_q   <= '0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      req_q       <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      req_q       <= (state_d == S_FETCH);
      valid_q     <= (state_d == S_EXEC);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign trap_addr   = trap_addr_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed table, reset corner case, random run
// against a per-instruction reference model of the PC/retire/trap rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_valid;
  logic        branch;
  logic        pc_update;
  logic        pc_target_src;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] trap_addr;
  logic [31:0] retired;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .instr_valid   (instr_valid),
    .branch        (branch),
    .pc_update     (pc_update),
    .pc_target_src (pc_target_src),
    .imm           (imm),
    .alu_result    (alu_result),
    .halt          (halt),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .trap          (trap),
    .trap_addr     (trap_addr),
    .retired       (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural view only
  logic [31:0] ref_pc;
  logic [31:0] ref_retired;
  logic        ref_trap;
  logic [31:0] ref_trap_addr;

  typedef struct {
    logic [31:0] word;
    int          rdy;
    int          rv;
    logic        br;
    logic        pu;
    logic        src;
    logic [31:0] immv;
    logic [31:0] aluv;
    logic        hlt;
    logic [31:0] exp_pc;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ref_pc        = RST_PC;
    ref_retired   = 32'd0;
    ref_trap      = 1'b0;
    ref_trap_addr = 32'd0;
  endtask

  // One full instruction; entered with the DUT in FETCH, #1 after an edge.
  task automatic do_instr(input vec_t v);
    logic [31:0] nxt;
    int          req_cycles;
    halt       = v.hlt;
    req_cycles = 0;
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("addr_in_fetch", imem_addr, ref_pc);
    for (int i = 0; i < v.rdy; i++) begin
      if (imem_req === 1'b1 && imem_addr === ref_pc) req_cycles++;
      tick();
    end
    if (imem_req === 1'b1 && imem_addr === ref_pc) req_cycles++;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("req_cycles", 32'(req_cycles), 32'(v.rdy + 1));
    chk("req_in_wait", 32'(imem_req), 32'd0);
    for (int i = 0; i < v.rv; i++) begin
      chk("valid_in_wait", 32'(instr_valid), 32'd0);
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = v.word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid_in_exec", 32'(instr_valid), 32'd1);
    chk("instr", instr, v.word);
    chk("opcode", 32'(opcode), 32'(v.word[6:0]));
    chk("funct3", 32'(funct3), 32'(v.word[14:12]));
    chk("funct7", 32'(funct7), 32'(v.word[31:25]));
    chk("pc_plus4", pc_plus4, ref_pc + 32'd4);
    branch        = v.br;
    pc_update     = v.pu;
    pc_target_src = v.src;
    imm           = v.immv;
    alu_result    = v.aluv;
    tick();
    branch        = 1'b0;
    pc_update     = 1'b0;
    pc_target_src = 1'b0;
    imm           = $urandom;
    alu_result    = $urandom;
    // Model: target from the architectural rules
    if (!(v.br || v.pu))  nxt = ref_pc + 32'd4;
    else if (!v.src)      nxt = ref_pc + v.immv;
    else                  nxt = {v.aluv[31:1], 1'b0};
    if (nxt % 4 != 0) begin
      ref_trap      = 1'b1;
      ref_trap_addr = nxt;
    end else begin
      ref_pc      = nxt;
      ref_retired = ref_retired + 32'd1;
    end
    chk("pc", pc, ref_pc);
    chk("retired", retired, ref_retired);
    chk("trap", 32'(trap), 32'(ref_trap));
    chk("trap_addr", trap_addr, ref_trap_addr);
    chk("valid_after_exec", 32'(instr_valid), 32'd0);
    chk("instr_held", instr, v.word);
    if (ref_trap) begin
      for (int i = 0; i < 3; i++) begin
        chk("req_in_trap", 32'(imem_req), 32'd0);
        chk("pc_in_trap", pc, ref_pc);
        tick();
      end
    end else if (v.hlt) begin
      chk("req_in_halt0", 32'(imem_req), 32'd0);
      tick();
      chk("req_in_halt1", 32'(imem_req), 32'd0);
      chk("valid_in_halt", 32'(instr_valid), 32'd0);
      halt = 1'b0;
      tick();
    end
    halt = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    branch = 1'b0; pc_update = 1'b0; pc_target_src = 1'b0; imm = '0; alu_result = '0;
    halt = 1'b0;

    //          word          rdy rv br pu src imm            alu            hlt exp_pc        trap
    vecs[0] = '{32'h0050_0093, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0040_0004, 0};
    vecs[1] = '{32'h00C0_006F, 0, 1, 0, 1, 0, 32'hC,         32'h0,         0, 32'h0040_0010, 0};
    vecs[2] = '{32'hFE00_0CE3, 1, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,         0, 32'h0040_0008, 0};
    vecs[3] = '{32'h0080_006F, 0, 0, 0, 1, 0, 32'h8,         32'h0,         0, 32'h0040_0010, 0};
    vecs[4] = '{32'hFE00_0CE3, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,         0, 32'h0040_0014, 0};
    vecs[5] = '{32'h0000_80E7, 0, 0, 0, 1, 1, 32'h0,         32'h0040_0101, 0, 32'h0040_0100, 0};
    vecs[6] = '{32'h0020_8133, 3, 4, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0040_0104, 0};
    vecs[7] = '{32'h0010_0193, 0, 2, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0040_0108, 0};
    vecs[8] = '{32'h4011_0233, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0040_010C, 0};
    vecs[9] = '{32'h0000_80E7, 0, 0, 0, 1, 1, 32'h0,         32'h0040_0103, 0, 32'h0040_010C, 1};

    model_reset();
    tick();
    tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_trap_addr", trap_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_instr(vecs[i]);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_trap", i), 32'(trap), 32'(vecs[i].exp_trap));
    end
    chk("trap_addr_jalr", trap_addr, 32'h0040_0102);

    // Reset pulsed mid-WAIT, stale rvalid one cycle after release
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    chk("midwait_rst_pc", pc, RST_PC);
    chk("midwait_rst_retired", retired, 32'd0);
    tick();
    reset = 1'b1;
    chk("rel_req", 32'(imem_req), 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_req", 32'(imem_req), 32'd1);
    chk("stale_addr", imem_addr, RST_PC);
    chk("stale_valid", 32'(instr_valid), 32'd0);
    chk("stale_instr", instr, 32'd0);
    chk("stale_retired", retired, 32'd0);
    do_instr(vecs[0]);

    // Randomized run against the reference model
    for (int n = 0; n < 60; n++) begin
      rv.word = $urandom;
      rv.rdy  = int'($urandom_range(0, 3));
      rv.rv   = int'($urandom_range(0, 3));
      rv.br   = 1'($urandom_range(0, 1));
      rv.pu   = ($urandom_range(0, 3) == 0);
      rv.src  = 1'($urandom_range(0, 1));
      rv.immv = $urandom;
      rv.aluv = $urandom;
      if ($urandom_range(0, 15) != 0) begin
        rv.immv[1:0] = 2'b00;
        rv.aluv[1]   = 1'b0;
      end
      rv.hlt      = ($urandom_range(0, 7) == 0);
      rv.exp_pc   = 32'd0;
      rv.exp_trap = 1'b0;
      do_instr(rv);
      if (ref_trap) break;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
